overlay_mix: RTL and testbench

- Per-pixel overlay stage on the video input path, generalised from the single-mode "fold" overlay.
- Consumes a PAT_W-bit pattern stream (one word per active pixel, from an AXI read source) and a CH-channel, CW-bit pixel stream.
- Applies one of several selectable pixel operations where the selected pattern bit is set.
- Adds a mode-change display timeout, stream underrun detection and a registered, latency-aligned output.

---
 rtl/overlay_pkg.sv | 18 +
 rtl/overlay_mix_if.sv | 44 ++++
 rtl/pipe_delay.sv | 25 ++
 rtl/overlay_mix.sv | 138 +++++++++++++
 tb/tb_overlay_mix.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay_mix pixel overlay stage.
package overlay_pkg;

    typedef enum logic [1:0] {
        OP_PASS   = 2'd0,
        OP_FOLD   = 2'd1,
        OP_INVERT = 2'd2,
        OP_DIM    = 2'd3
    } op_e;

    localparam int unsigned UR_W = 16;

    // Saturating increment for the underrun counter.
    function automatic logic [UR_W-1:0] sat_inc(input logic [UR_W-1:0] v);
        return (v == '1) ? v : v + UR_W'(1);
    endfunction

endpackage

// File: rtl/overlay_mix_if.sv
// Pixel, pattern and status signals of overlay_mix; ch_en_i exists only with OVERLAY_CHANNEL_MASK_EN.
interface overlay_mix_if
    import overlay_pkg::*;
#(
    parameter int unsigned CH    = 3,
    parameter int unsigned CW    = 8,
    parameter int unsigned PAT_W = 8
);
    localparam int unsigned MODE_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic [MODE_W-1:0]  mode_i;
    logic [1:0]         op_i;
    logic               vs_i;
    logic               de_i;
    logic [CH*CW-1:0]   data_i;
    logic [PAT_W-1:0]   pat_i;
    logic               pat_vld_i;
    logic               pat_rdy_o;
    logic [CH*CW-1:0]   data_o;
    logic               de_o;
    logic               vs_o;
    logic               underrun_o;
    logic [UR_W-1:0]    underrun_cnt_o;
`ifdef OVERLAY_CHANNEL_MASK_EN
    logic [CH-1:0]      ch_en_i;
`endif

    modport slave (
        input  mode_i, op_i, vs_i, de_i, data_i, pat_i, pat_vld_i,
`ifdef OVERLAY_CHANNEL_MASK_EN
        input  ch_en_i,
`endif
        output pat_rdy_o, data_o, de_o, vs_o, underrun_o, underrun_cnt_o
    );

    modport master (
        output mode_i, op_i, vs_i, de_i, data_i, pat_i, pat_vld_i,
`ifdef OVERLAY_CHANNEL_MASK_EN
        output ch_en_i,
`endif
        input  pat_rdy_o, data_o, de_o, vs_o, underrun_o, underrun_cnt_o
    );

endinterface

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous reset; used for pattern and sync delays.
module pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/overlay_mix.sv
// Per-pixel overlay: selectable fold/invert/dim where the chosen pattern bit is set.
// Optional per-channel enable via OVERLAY_CHANNEL_MASK_EN.
module overlay_mix
    import overlay_pkg::*;
#(
    parameter int unsigned CH      = 3,
    parameter int unsigned CW      = 8,
    parameter int unsigned PAT_W   = 8,
    parameter int unsigned LAT     = 5,
    parameter int unsigned TIMEOUT = 200000000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    overlay_mix_if.slave  bus
);

    localparam int unsigned MODE_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0]   pat_in_c;
    logic [PAT_W-1:0]   pat_d;
    logic [1:0]         sync_q;
    logic               underrun_c;
    logic               vs_rise_c;
    logic               pat_bit_c;
    logic               act_c;
    logic [CH-1:0]      ch_en_c;
    logic [CW-1:0]      px_c;
    logic [CW-1:0]      py_c;
    logic [CH*CW-1:0]   mix_c;

    logic [MODE_W-1:0]  mode_q;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               en_q;
    logic [CH*CW-1:0]   data_q;
    logic               underrun_q;
    logic [UR_W-1:0]    underrun_cnt_q;

    assign bus.pat_rdy_o = bus.de_i;
    assign underrun_c    = bus.de_i && !bus.pat_vld_i;
    assign pat_in_c      = (bus.de_i && bus.pat_vld_i) ? bus.pat_i : '0;

    pipe_delay #(.WIDTH(PAT_W), .DEPTH(LAT)) u_pat_dly (
        .clk (clk_i),
        .rst (rst_i),
        .d   (pat_in_c),
        .q   (pat_d)
    );

    // de/vs share the one-cycle output latency of the pixel path.
    pipe_delay #(.WIDTH(2), .DEPTH(1)) u_sync_dly (
        .clk (clk_i),
        .rst (rst_i),
        .d   ({bus.de_i, bus.vs_i}),
        .q   (sync_q)
    );

    assign vs_rise_c = bus.vs_i && !sync_q[0];

    // Out-of-range mode values only exist when PAT_W is not a power of two.
    if ((1 << MODE_W) == PAT_W) begin : g_sel_full
        assign pat_bit_c = pat_d[mode_q];
    end else begin : g_sel_guard
        assign pat_bit_c = (mode_q < MODE_W'(PAT_W)) && pat_d[mode_q];
    end

    assign act_c = en_q && pat_bit_c && (op_q != OP_PASS);

`ifdef OVERLAY_CHANNEL_MASK_EN
    assign ch_en_c = bus.ch_en_i;
`else
    assign ch_en_c = '1;
`endif

    always_comb begin
        mix_c = bus.data_i;
        px_c  = '0;
        py_c  = '0;
        for (int c = 0; c < int'(CH); c++) begin
            px_c = bus.data_i[c*CW +: CW];
            py_c = px_c;
            if (act_c && ch_en_c[c]) begin
                case (op_q)
                    // Below half: H-1-x is the low-bit complement; above: drop the MSB.
                    OP_FOLD:   py_c = {1'b0, px_c[CW-1] ? px_c[CW-2:0] : ~px_c[CW-2:0]};
                    OP_INVERT: py_c = ~px_c;
                    OP_DIM:    py_c = px_c >> 1;
                    default:   py_c = px_c;
                endcase
            end
            mix_c[c*CW +: CW] = py_c;
        end
    end

    // Display window: restarts on any mode/op change, then closes after TIMEOUT cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= '0;
            op_q   <= OP_PASS;
            cnt_q  <= '0;
            en_q   <= 1'b1;
        end else if ((bus.mode_i != mode_q) || (op_e'(bus.op_i) != op_q)) begin
            mode_q <= bus.mode_i;
            op_q   <= op_e'(bus.op_i);
            cnt_q  <= '0;
            en_q   <= 1'b1;
        end else if (cnt_q < CNT_W'(TIMEOUT)) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            en_q   <= 1'b1;
        end else begin
            en_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q         <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            data_q <= mix_c;
            if (underrun_c) begin
                underrun_q     <= 1'b1;
                underrun_cnt_q <= sat_inc(underrun_cnt_q);
            end else if (vs_rise_c) begin
                underrun_q     <= 1'b0;
            end
        end
    end

    assign bus.data_o         = data_q;
    assign bus.de_o           = sync_q[1];
    assign bus.vs_o           = sync_q[0];
    assign bus.underrun_o     = underrun_q;
    assign bus.underrun_cnt_o = underrun_cnt_q;

endmodule

// File: tb/tb_overlay_mix.sv
// Self-checking bench for overlay_mix: vector table, latency, timeout, underrun and reset sequences.
module tb_overlay_mix;
    import overlay_pkg::*;

    localparam int unsigned CH = 3, CW = 8, PAT_W = 8, LAT = 5, TMO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    overlay_mix_if #(.CH(CH), .CW(CW), .PAT_W(PAT_W)) bus ();

    overlay_mix #(
        .CH(CH), .CW(CW), .PAT_W(PAT_W), .LAT(LAT), .TIMEOUT(TMO), .CNT_W(32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        check;
        logic [23:0] data;
        logic        de;
        logic        vs;
    } exp_t;

    typedef struct {
        op_e         op;
        logic [2:0]  mode;
        logic [7:0]  pat;
        logic [23:0] pix;
        logic [23:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Push expectation for the inputs now on the bus, clock once, pop and compare.
    task automatic tick(input logic check, input logic [23:0] d);
        exp_t e;
        e.check = check;
        e.data  = d;
        e.de    = bus.de_i;
        e.vs    = bus.vs_i;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.check) begin
            chk("data_o", 32'(bus.data_o), 32'(e.data));
            chk("de_o",   32'(bus.de_o),   32'(e.de));
            chk("vs_o",   32'(bus.vs_o),   32'(e.vs));
        end
    endtask

    // Reference per-channel operation written arithmetically.
    function automatic logic [23:0] model(input op_e op, input logic [23:0] pix);
        logic [23:0] r;
        int x;
        for (int c = 0; c < 3; c++) begin
            x = int'(pix[c*8 +: 8]);
            case (op)
                OP_FOLD:   x = (x >= 128) ? x - 128 : 127 - x;
                OP_INVERT: x = 255 - x;
                OP_DIM:    x = x / 2;
                default:   x = x;
            endcase
            r[c*8 +: 8] = 8'(x);
        end
        return r;
    endfunction

    task automatic drive(input logic de, input logic vld, input logic [7:0] pat, input logic [23:0] pix);
        bus.de_i      = de;
        bus.pat_vld_i = vld;
        bus.pat_i     = pat;
        bus.data_i    = pix;
    endtask

    // Restart the window with vec.op, fill the pattern line, check the last two pixels.
    task automatic run_vec(input vec_t v);
        for (int k = 0; k < 7; k++) begin
            bus.mode_i = v.mode;
            bus.op_i   = (k == 0) ? ((v.op == OP_FOLD) ? OP_INVERT : OP_FOLD) : v.op;
            drive(1'b1, 1'b1, v.pat, v.pix);
            tick(k >= 5, v.exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{OP_FOLD,   3'd0, 8'h01, 24'h807FFF, 24'h00007F};
        tbl[1] = '{OP_FOLD,   3'd0, 8'hFE, 24'h807FFF, 24'h807FFF};
        tbl[2] = '{OP_INVERT, 3'd0, 8'h01, 24'h123456, 24'hEDCBA9};
        tbl[3] = '{OP_DIM,    3'd0, 8'h01, 24'h123456, 24'h091A2B};
        tbl[4] = '{OP_PASS,   3'd0, 8'h01, 24'h123456, 24'h123456};
        tbl[5] = '{OP_INVERT, 3'd3, 8'h08, 24'h000000, 24'hFFFFFF};
        tbl[6] = '{OP_DIM,    3'd7, 8'h80, 24'hFF0102, 24'h7F0001};
        tbl[7] = '{OP_FOLD,   3'd7, 8'h7F, 24'h123456, 24'h123456};
        tbl[8] = '{OP_FOLD,   3'd2, 8'h04, 24'h001020, 24'h7F6F5F};

        bus.mode_i = '0;
        bus.op_i   = OP_PASS;
        bus.vs_i   = 1'b0;
`ifdef OVERLAY_CHANNEL_MASK_EN
        bus.ch_en_i = 3'b111;
`endif
        drive(1'b1, 1'b1, 8'hFF, 24'hABCDEF);
        repeat (3) @(posedge clk);
        #1;
        chk("rst data_o", 32'(bus.data_o), 32'h0);
        chk("rst de_o", 32'(bus.de_o), 32'h0);
        chk("rst vs_o", 32'(bus.vs_o), 32'h0);
        chk("rst underrun_o", 32'(bus.underrun_o), 32'h0);
        chk("rst underrun_cnt_o", 32'(bus.underrun_cnt_o), 32'h0);
        rst = 1'b0;

        // Underrun: three pixels without pattern words, later pass unchanged.
        for (int k = 0; k < 13; k++) begin
            bus.op_i = (k == 0) ? OP_PASS : OP_FOLD;
            drive(1'b1, !(k >= 5 && k <= 7), 8'h01, 24'h807FFF);
            if (k == 5) begin
                #1;
                chk("pat_rdy de=1", 32'(bus.pat_rdy_o), 32'h1);
            end
            tick(k >= 9, (k == 9) ? 24'h00007F : 24'h807FFF);
        end
        chk("underrun_cnt 3", 32'(bus.underrun_cnt_o), 32'd3);
        chk("underrun_o set", 32'(bus.underrun_o), 32'h1);

        drive(1'b0, 1'b0, 8'h00, 24'h000000);
        bus.vs_i = 1'b1;
        #1;
        chk("pat_rdy de=0", 32'(bus.pat_rdy_o), 32'h0);
        tick(1'b1, 24'h000000);
        chk("vs rise clears", 32'(bus.underrun_o), 32'h0);
        chk("count holds", 32'(bus.underrun_cnt_o), 32'd3);
        bus.vs_i = 1'b0;
        tick(1'b0, 24'h0);

        // vs rise together with an underrun: set wins.
        bus.vs_i = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 24'h000000);
        tick(1'b0, 24'h0);
        chk("set wins over vs", 32'(bus.underrun_o), 32'h1);
        chk("underrun_cnt 4", 32'(bus.underrun_cnt_o), 32'd4);
        bus.vs_i = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 24'h000000);
        tick(1'b0, 24'h0);
        bus.vs_i = 1'b1;
        tick(1'b0, 24'h0);
        chk("second rise clears", 32'(bus.underrun_o), 32'h0);
        bus.vs_i = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

`ifdef OVERLAY_CHANNEL_MASK_EN
        bus.ch_en_i = 3'b010;
        run_vec('{OP_FOLD, 3'd0, 8'h01, 24'h807FFF, 24'h8000FF});
        bus.ch_en_i = 3'b111;
`endif

        // LAT alignment: a single pattern word at k=6 affects only the pixel at k=11.
        for (int k = 0; k < 14; k++) begin
            bus.mode_i = 3'd0;
            bus.op_i   = (k == 0) ? OP_DIM : OP_INVERT;
            drive(1'b1, 1'b1, (k == 6) ? 8'h01 : 8'h00, 24'h123456);
            tick(k >= 5 && k <= 12, (k == 11) ? model(OP_INVERT, 24'h123456) : 24'h123456);
        end

        // Timeout: mode change opens an 11-cycle window; an op change reopens it.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 8'hFF, 24'h123456);
            tick(1'b0, 24'h0);
        end
        for (int j = 0; j < 29; j++) begin
            logic [23:0] e;
            bus.mode_i = 3'd1;
            bus.op_i   = (j < 15) ? OP_INVERT : OP_DIM;
            drive(1'b1, 1'b1, 8'hFF, 24'h123456);
            if (j >= 1 && j <= 11)       e = model(OP_INVERT, 24'h123456);
            else if (j >= 16 && j <= 26) e = model(OP_DIM, 24'h123456);
            else                         e = 24'h123456;
            tick(j >= 1, e);
        end

        // Counter saturation.
        drive(1'b1, 1'b0, 8'h00, 24'h000000);
        for (int k = 0; k < 70000; k++) tick(1'b0, 24'h0);
        chk("underrun_cnt sat", 32'(bus.underrun_cnt_o), 32'h0000FFFF);
        chk("underrun_o sat", 32'(bus.underrun_o), 32'h1);

        // Reset mid-frame.
        bus.vs_i = 1'b1;
        drive(1'b1, 1'b1, 8'hFF, 24'h123456);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst data_o", 32'(bus.data_o), 32'h0);
        chk("mid rst de_o", 32'(bus.de_o), 32'h0);
        chk("mid rst vs_o", 32'(bus.vs_o), 32'h0);
        chk("mid rst underrun_o", 32'(bus.underrun_o), 32'h0);
        chk("mid rst underrun_cnt_o", 32'(bus.underrun_cnt_o), 32'h0);
        chk("mid rst en", 32'(dut.en_q), 32'h1);
        rst = 1'b0;
        bus.vs_i = 1'b0;
        tick(1'b0, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
